// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, state encoding and flag indices
// for the ALU control FSM.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_BRANCH,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_JS   = 4'hC;
  localparam logic [3:0] OP_NOP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_RSV  = 4'hF;

  // flags = {C,S,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;

  function automatic logic is_alu(
    input logic [3:0] op
  );
    return ~op[3];
  endfunction

  function automatic logic is_jmp(
    input logic [3:0] op
  );
    return (op >= OP_JMP) && (op <= OP_JS);
  endfunction

endpackage

// File: rtl/alu_ctrl_flags.sv
// Registered {C,S,Z} status flags.
// Ports: clk, rst_n, upd_i, arit_i, zero_i/carry_i/sign_i, flags_o.
module alu_ctrl_flags
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd_i,
  input  logic       arit_i,
  input  logic       zero_i,
  input  logic       carry_i,
  input  logic       sign_i,
  output logic [2:0] flags_o
);

  logic [2:0] flags_q;
  logic [2:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (upd_i) begin
      flags_d[FLAG_Z] = zero_i;
      flags_d[FLAG_S] = sign_i;
      // logic ops clear carry
      flags_d[FLAG_C] = arit_i & carry_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle ALU controller: IDLE->DECODE->EXEC/BRANCH.
// Ports: instr handshake, ALU select/flags, regfile, PC, status.
// Option: ALU_CTRL_TRAP_EN makes opcode 0xF trap to HALT.
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_sign,
  output logic [1:0]  alu_op,
  output logic        arit,
  output logic [3:0]  rd_addr_a,
  output logic [3:0]  rd_addr_b,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic        wr_sel,
  output logic [3:0]  imm,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic [7:0]  pc_tgt,
  output logic [2:0]  flags,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q;
  state_e      state_d;
  logic [15:0] instr_q;
  logic [15:0] instr_d;
  logic [3:0]  op;
  logic        take;
  logic        flag_upd;
`ifdef ALU_CTRL_TRAP_EN
  logic        ill_set;
  logic        ill_q;
`endif

  assign op = instr_q[15:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    take = 1'b0;
    unique case (1'b1)
      op == OP_JMP: take = 1'b1;
      op == OP_JZ:  take = flags[FLAG_Z];
      op == OP_JC:  take = flags[FLAG_C];
      op == OP_JS:  take = flags[FLAG_S];
      default:      take = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_ready = 1'b0;
    alu_op      = '0;
    arit        = 1'b0;
    rd_addr_a   = '0;
    rd_addr_b   = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_sel      = 1'b0;
    imm         = '0;
    pc_inc      = 1'b0;
    pc_ld       = 1'b0;
    pc_tgt      = '0;
    halted      = 1'b0;
    flag_upd    = 1'b0;
`ifdef ALU_CTRL_TRAP_EN
    ill_set     = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        unique case (1'b1)
          is_alu(op),
          op == OP_LDI:  state_d = S_EXEC;
          is_jmp(op):    state_d = S_BRANCH;
          op == OP_HALT: state_d = S_HALT;
`ifdef ALU_CTRL_TRAP_EN
          op == OP_RSV: begin
            ill_set = 1'b1;
            state_d = S_HALT;
          end
`endif
          // NOP, and reserved when not trapping
          default: pc_inc = 1'b1;
        endcase
      end
      S_EXEC: begin
        alu_op    = op[1:0];
        arit      = op[2];
        rd_addr_a = instr_q[7:4];
        rd_addr_b = instr_q[3:0];
        wr_en     = 1'b1;
        wr_addr   = instr_q[11:8];
        wr_sel    = (op == OP_LDI);
        imm       = (op == OP_LDI) ? instr_q[3:0] : 4'h0;
        pc_inc    = 1'b1;
        flag_upd  = is_alu(op);
        state_d   = S_IDLE;
      end
      S_BRANCH: begin
        if (take) begin
          pc_ld  = 1'b1;
          pc_tgt = instr_q[7:0];
        end else begin
          pc_inc = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // reset kills strobes in the same cycle
    if (!rst_n) begin
      instr_ready = 1'b0;
      alu_op      = '0;
      arit        = 1'b0;
      rd_addr_a   = '0;
      rd_addr_b   = '0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_sel      = 1'b0;
      imm         = '0;
      pc_inc      = 1'b0;
      pc_ld       = 1'b0;
      pc_tgt      = '0;
      halted      = 1'b0;
      flag_upd    = 1'b0;
`ifdef ALU_CTRL_TRAP_EN
      ill_set     = 1'b0;
`endif
    end
  end

  alu_ctrl_flags u_flags (
    .clk     (clk),
    .rst_n   (rst_n),
    .upd_i   (flag_upd),
    .arit_i  (arit),
    .zero_i  (alu_zero),
    .carry_i (alu_carry),
    .sign_i  (alu_sign),
    .flags_o (flags)
  );

`ifdef ALU_CTRL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ill_q <= 1'b0;
    else if (ill_set) ill_q <= 1'b1;
  end
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

endmodule
